// File: rtl/prog_loader_pkg.sv
// Shared processor package: memory geometry defaults and the loader FSM encoding.
package prog_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 13;
  localparam int unsigned DATA_W_DEF = 18;
  localparam int unsigned COUNT_W    = 13;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_W0,
    S_W1,
    S_W2,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles three stream bytes into one memory word; B0 supplies only the bits above 16.
module word_packer
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [1:0]        sel,
  input  logic [7:0]        data,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned HI_W = DATA_W - 16;

  logic [HI_W-1:0] b0;
  logic [7:0]      b1;
  logic [7:0]      b2;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      b0 <= '0;
      b1 <= '0;
      b2 <= '0;
    end else if (load) begin
      case (sel)
        2'd0:    b0 <= data[HI_W-1:0];
        2'd1:    b1 <= data;
        default: b2 <= data;
      endcase
    end
  end

  assign word = {b0, b1, b2};

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses length, packs words, writes memory, verifies XOR checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              proc_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t state, state_next;

  logic [4:0]         len_hi;
  logic [COUNT_W-1:0] len;
  logic [COUNT_W-1:0] words_left;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         csum;
  logic               xfer;
  logic               launch;
  logic               pack_load;
  logic [1:0]         pack_sel;
  logic [DATA_W-1:0]  word;

  assign len  = {len_hi, in_data};
  assign xfer = in_valid && in_ready;

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .load  (pack_load),
    .sel   (pack_sel),
    .data  (in_data),
    .word  (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    proc_reset = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    launch     = 1'b0;
    pack_load  = 1'b0;
    pack_sel   = 2'd0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        proc_reset = (state != S_DONE);
        done       = (state == S_DONE);
        error      = (state == S_ERR);
        if (start) begin
          launch     = 1'b1;
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = (len != '0) ? S_W0 : S_CHK;
      end
      S_W0, S_W1, S_W2: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        pack_load = in_valid;
        pack_sel  = (state == S_W0) ? 2'd0 : (state == S_W1) ? 2'd1 : 2'd2;
        if (in_valid) begin
          state_next = (state == S_W0) ? S_W1 : (state == S_W1) ? S_W2 : S_WRITE;
        end
      end
      S_WRITE: begin
        busy       = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = addr;
        mem_data   = word;
        state_next = (words_left == COUNT_W'(1)) ? S_CHK : S_W0;
      end
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi     <= '0;
      words_left <= '0;
      addr       <= '0;
      csum       <= '0;
    end else if (launch) begin
      len_hi     <= '0;
      words_left <= '0;
      addr       <= ADDR_W'(BASE_ADDR);
      csum       <= '0;
    end else begin
      // The checksum byte itself is excluded from the running XOR.
      if (xfer && state != S_CHK) csum <= csum ^ in_data;
      if (xfer && state == S_LEN_HI) len_hi <= in_data[4:0];
      if (xfer && state == S_LEN_LO) words_left <= len;
      if (state == S_WRITE) begin
        words_left <= words_left - COUNT_W'(1);
        addr       <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: base-0 and base-8191 instances share one byte stream.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        a_in_ready, a_mem_we, a_proc_reset, a_busy, a_done, a_error;
  logic [12:0] a_mem_addr;
  logic [17:0] a_mem_data;
  logic        b_in_ready, b_mem_we, b_proc_reset, b_busy, b_done, b_error;
  logic [12:0] b_mem_addr;
  logic [17:0] b_mem_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [17:0] data;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [7:0]  stream[$];
  logic [17:0] words[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(13), .DATA_W(18), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_we(a_mem_we),
    .proc_reset(a_proc_reset), .busy(a_busy), .done(a_done), .error(a_error)
  );

  prog_loader #(.ADDR_W(13), .DATA_W(18), .BASE_ADDR(8191)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_in_ready), .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_we(b_mem_we),
    .proc_reset(b_proc_reset), .busy(b_busy), .done(b_done), .error(b_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops the oldest expected word.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (a_mem_we !== 1'b0) begin
      if (qa.size() == 0) check("a_spurious_we", 32'(a_mem_we), 32'd0);
      else begin
        e = qa.pop_front();
        check("a_addr", 32'(a_mem_addr), 32'(e.idx % 8192));
        check("a_data", 32'(a_mem_data), 32'(e.data));
      end
    end
    if (b_mem_we !== 1'b0) begin
      if (qb.size() == 0) check("b_spurious_we", 32'(b_mem_we), 32'd0);
      else begin
        e = qb.pop_front();
        check("b_addr", 32'(b_mem_addr), 32'((8191 + e.idx) % 8192));
        check("b_data", 32'(b_mem_data), 32'(e.data));
      end
    end
  end

  task automatic make_stream(input bit push, input bit force_chk, input logic [7:0] chk);
    logic [12:0] c;
    logic [7:0]  x;
    logic [17:0] w;
    c = 13'(words.size());
    x = 8'h00;
    stream.delete();
    stream.push_back({3'b000, c[12:8]});
    stream.push_back(c[7:0]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      stream.push_back({6'b0, w[17:16]});
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
      if (push) begin
        qa.push_back('{i, w});
        qb.push_back('{i, w});
      end
    end
    foreach (stream[i]) x = x ^ stream[i];
    stream.push_back(force_chk ? chk : x);
  endtask

  // Called at a negedge; offers the byte until accepted, returns at the next negedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      in_valid = 1'b0;
      in_data  = b;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(a_in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_range(input int from, input int upto, input bit gap);
    for (int i = from; i < upto; i++) send_byte(stream[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_flags"}, 32'({a_in_ready, a_mem_we, a_proc_reset, a_busy, a_done, a_error}), 32'b001000);
    check({tag, "_b_flags"}, 32'({b_in_ready, b_mem_we, b_proc_reset, b_busy, b_done, b_error}), 32'b001000);
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp);
    check({tag, "_a_status"}, 32'({a_proc_reset, a_busy, a_done, a_error}), 32'(exp));
    check({tag, "_b_status"}, 32'({b_proc_reset, b_busy, b_done, b_error}), 32'(exp));
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_a_addr", 32'(a_mem_addr), 32'd0);
    check("reset_a_data", 32'(a_mem_data), 32'd0);
    check("reset_b_addr", 32'(b_mem_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Bytes offered while idle must not be taken.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(a_in_ready), 32'd0);
    check("idle_busy", 32'(a_busy), 32'd0);
    in_valid = 1'b0;

    // Two-word load with good checksum; base 8191 instance wraps to 0.
    words = '{18'h01234, 18'h3FFFF};
    make_stream(1'b1, 1'b0, 8'h00);
    do_start();
    check("lenhi_busy", 32'({a_busy, a_in_ready}), 32'b11);
    send_range(0, stream.size(), 1'b0);
    check_status("good", 4'b0010);

    // Same payload, wrong checksum: writes still happen, error reported.
    make_stream(1'b1, 1'b1, 8'h00);
    do_start();
    send_range(0, stream.size(), 1'b0);
    check_status("badchk", 4'b1001);
    do_start();
    check_status("restart", 4'b1100);
    // Fresh start from ERR; a start pulse mid-load must be ignored.
    words = '{18'h2A5A5, 18'h15A5A, 18'h00001};
    make_stream(1'b1, 1'b0, 8'h00);
    send_range(0, 5, 1'b0);
    do_start();
    send_range(5, stream.size(), 1'b0);
    check_status("midstart", 4'b0010);

    // Zero-length load: straight to CHK, done right after checksum byte.
    words.delete();
    make_stream(1'b1, 1'b0, 8'h00);
    do_start();
    send_range(0, stream.size(), 1'b0);
    check_status("zero", 4'b0010);

    // in_valid toggling every other cycle.
    words = '{18'h01234, 18'h3FFFF};
    make_stream(1'b1, 1'b0, 8'h00);
    do_start();
    send_range(0, stream.size(), 1'b1);
    check_status("toggle", 4'b0010);

    // Reset after the second byte of the first word aborts with no write.
    words = '{18'h12345, 18'h0ABCD};
    make_stream(1'b0, 1'b0, 8'h00);
    do_start();
    send_range(0, 4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("abort");
    repeat (4) @(negedge clk);
    check_idle_outputs("abort_hold");
    make_stream(1'b1, 1'b0, 8'h00);
    do_start();
    send_range(0, stream.size(), 1'b0);
    check_status("after_abort", 4'b0010);

    // Longer random load.
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back(18'($urandom));
    make_stream(1'b1, 1'b0, 8'h00);
    do_start();
    send_range(0, stream.size(), 1'b0);
    check_status("random", 4'b0010);

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
